// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, with round keys requested by index.
// Optional `busy` status output is enabled by defining AES_DEC_BUSY_OUT_EN.
module aes_decrypt_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    input  logic         key_expansion_done,
    output logic [3:0]   desired_round,
    output logic [127:0] data_out,
    output logic         done
`ifdef AES_DEC_BUSY_OUT_EN
    ,
    output logic         busy
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_KEY, ROUND, FINAL} state_t;

    // Entry x of the inverse S-box sits at index x (index 0 is the most significant byte).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    state_t       state;
    state_t       state_next;
    logic [127:0] aes_state;
    logic [3:0]   round_next;
    logic         done_next;
    logic         load_init;
    logic         load_round;
    logic         load_final;
    logic [127:0] sub_shifted;
    logic [127:0] round_out;
    logic [127:0] final_out;

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c - row + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8 * i -: 8] = INV_SBOX[s[127 - 8 * i -: 8]];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficient k is applied as a sum of x, 2x, 4x, 8x selected by its bits.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = gf_mul_const(a0, 4'he) ^ gf_mul_const(a1, 4'hb) ^
                                   gf_mul_const(a2, 4'hd) ^ gf_mul_const(a3, 4'h9);
            r[119 - 32 * c -: 8] = gf_mul_const(a0, 4'h9) ^ gf_mul_const(a1, 4'he) ^
                                   gf_mul_const(a2, 4'hb) ^ gf_mul_const(a3, 4'hd);
            r[111 - 32 * c -: 8] = gf_mul_const(a0, 4'hd) ^ gf_mul_const(a1, 4'h9) ^
                                   gf_mul_const(a2, 4'he) ^ gf_mul_const(a3, 4'hb);
            r[103 - 32 * c -: 8] = gf_mul_const(a0, 4'hb) ^ gf_mul_const(a1, 4'hd) ^
                                   gf_mul_const(a2, 4'h9) ^ gf_mul_const(a3, 4'he);
        end
        return r;
    endfunction

    assign sub_shifted = inv_sub_bytes(inv_shift_rows(aes_state));
    assign round_out   = inv_mix_columns(sub_shifted ^ key_in);
    assign final_out   = sub_shifted ^ key_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = WAIT_KEY;
            WAIT_KEY: if (key_expansion_done) state_next = ROUND;
            ROUND:    if (desired_round == 4'd1) state_next = FINAL;
            FINAL:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // The key index is registered, so the next index is chosen one cycle ahead of its use.
    always_comb begin
        round_next = desired_round;
        done_next  = 1'b0;
        load_init  = 1'b0;
        load_round = 1'b0;
        load_final = 1'b0;
        case (state)
            IDLE: begin
                round_next = start ? 4'd9 : 4'd10;
                load_init  = start;
            end
            WAIT_KEY: begin
                round_next = 4'd9;
            end
            ROUND: begin
                round_next = desired_round - 4'd1;
                load_round = 1'b1;
            end
            FINAL: begin
                round_next = 4'd10;
                load_final = 1'b1;
                done_next  = 1'b1;
            end
            default: begin
                round_next = 4'd10;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            desired_round <= 4'd10;
            done          <= 1'b0;
            data_out      <= '0;
            aes_state     <= '0;
        end else begin
            desired_round <= round_next;
            done          <= done_next;
            if (load_init) begin
                aes_state <= data_in ^ key_in;
            end else if (load_round) begin
                aes_state <= round_out;
            end
            if (load_final) begin
                data_out <= final_out;
            end
        end
    end

`ifdef AES_DEC_BUSY_OUT_EN
    assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS-197 vectors, key stalls, reset abort,
// back-to-back blocks and random blocks checked against a byte-level AES reference model.
module tb_aes_decrypt_core;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         key_expansion_done;
    logic [3:0]   desired_round;
    logic [127:0] data_out;
    logic         done;
`ifdef AES_DEC_BUSY_OUT_EN
    logic         busy;
`endif

    int           checks;
    int           errors;
    logic [7:0]   sbox_t [256];
    logic [7:0]   inv_t [256];
    logic [127:0] rk [0:10];
    logic [127:0] last_plain;

    aes_decrypt_core dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .data_in            (data_in),
        .key_in             (key_in),
        .key_expansion_done (key_expansion_done),
        .desired_round      (desired_round),
        .data_out           (data_out),
        .done               (done)
`ifdef AES_DEC_BUSY_OUT_EN
        ,
        .busy               (busy)
`endif
    );

    always #5 clk = ~clk;

    // The key-expansion side answers whatever index the core requests in the same cycle.
    assign key_in = (desired_round <= 4'd10) ? rk[desired_round] : 128'h0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) r = 8'(b);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15 - n -: 8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = ginv(8'(x));
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x] = s;
            inv_t[s]  = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Textbook inverse cipher on a 4x4 byte matrix, using the round keys currently in rk.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   col [4];
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = ct[127 - 8 * (4 * c + r) -: 8] ^ rk[10][127 - 8 * (4 * c + r) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c + r) % 4] = m[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m[r][c] = inv_t[t[r][c]] ^ rk[rnd][127 - 8 * (4 * c + r) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) col[r] = m[r][c];
                    m[0][c] = gmul(col[0], 8'h0e) ^ gmul(col[1], 8'h0b) ^ gmul(col[2], 8'h0d) ^ gmul(col[3], 8'h09);
                    m[1][c] = gmul(col[0], 8'h09) ^ gmul(col[1], 8'h0e) ^ gmul(col[2], 8'h0b) ^ gmul(col[3], 8'h0d);
                    m[2][c] = gmul(col[0], 8'h0d) ^ gmul(col[1], 8'h09) ^ gmul(col[2], 8'h0e) ^ gmul(col[3], 8'h0b);
                    m[3][c] = gmul(col[0], 8'h0b) ^ gmul(col[1], 8'h0d) ^ gmul(col[2], 8'h09) ^ gmul(col[3], 8'h0e);
                end
            end
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 8 * (4 * c + r) -: 8] = m[r][c];
        return res;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        check_output("idle_done", 128'(done), 128'(1'b0));
        check_output("idle_round", 128'(desired_round), 128'(4'd10));
    endtask

    // Caller is mid-cycle on entry; returns #1 after the done edge (or after a reset abort).
    task automatic apply_stimulus(input logic [127:0] ct, input logic [127:0] key, input int stall,
                                  input int mid_start_at, input int abort_at, input logic [127:0] required);
        logic [3:0] exp_round;
        expand_key(key);
        data_in            = ct;
        start              = 1'b1;
        key_expansion_done = (stall == 0);
        for (int k = 0; k <= stall + 11; k++) begin
            @(posedge clk);
            #1;
            if (k < stall + 2)        exp_round = 4'd9;
            else if (k <= stall + 10) exp_round = 4'(9 - (k - (stall + 1)));
            else                      exp_round = 4'd10;
            check_output("desired_round", 128'(desired_round), 128'(exp_round));
            check_output("done", 128'(done), 128'(k == stall + 11));
            if (k == stall + 11) begin
                check_output("plaintext", data_out, required);
                last_plain = required;
            end else begin
                check_output("data_out_held", data_out, last_plain);
            end
`ifdef AES_DEC_BUSY_OUT_EN
            check_output("busy", 128'(busy), 128'(k <= stall + 10));
`endif
            if (k == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                check_output("abort_done", 128'(done), 128'(1'b0));
                check_output("abort_data_out", data_out, 128'h0);
                check_output("abort_round", 128'(desired_round), 128'(4'd10));
`ifdef AES_DEC_BUSY_OUT_EN
                check_output("abort_busy", 128'(busy), 128'(1'b0));
`endif
                last_plain = '0;
                start = 1'b0;
                key_expansion_done = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            start   = (k == mid_start_at);
            data_in = {$urandom, $urandom, $urandom, $urandom};
            // With a stall, key_expansion_done drops again mid-block to show it is no longer examined.
            key_expansion_done = (k + 1 > stall) && !(stall > 0 && k + 1 > stall + 4);
        end
        start = 1'b0;
        key_expansion_done = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        clk = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        data_in = '0;
        key_expansion_done = 1'b1;
        checks = 0;
        errors = 0;
        last_plain = '0;
        for (int r = 0; r < 11; r++) rk[r] = '0;
        build_tables();
        #12;
        check_output("reset_done", 128'(done), 128'(1'b0));
        check_output("reset_data_out", data_out, 128'h0);
        check_output("reset_round", 128'(desired_round), 128'(4'd10));
`ifdef AES_DEC_BUSY_OUT_EN
        check_output("reset_busy", 128'(busy), 128'(1'b0));
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] FIPS-197 C.1 with an ignored mid-block start");
        apply_stimulus(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                       0, 4, -1, 128'h00112233445566778899aabbccddeeff);
        $display("[TB] FIPS-197 B back-to-back");
        apply_stimulus(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                       0, -1, -1, 128'h3243f6a8885a308d313198a2e0370734);
        idle_check();

        $display("[TB] key stall of 5 cycles");
        apply_stimulus(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                       5, -1, -1, 128'h3243f6a8885a308d313198a2e0370734);
        idle_check();

        $display("[TB] reset abort during round 5");
        apply_stimulus(128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                       0, -1, 5, 128'h3243f6a8885a308d313198a2e0370734);
        apply_stimulus(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                       0, -1, -1, 128'h00112233445566778899aabbccddeeff);

        $display("[TB] random blocks");
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            pt = model_decrypt(ct);
            apply_stimulus(ct, key, int'($urandom_range(0, 3)), -1, -1, pt);
            if (n % 2 == 1) idle_check();
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
